// File: rtl/cc_stats_if.sv
// cc_stats_if: component record stream (valid/ready) from cc_stats.
// master drives the record, slave returns ready.
interface cc_stats_if #(
    parameter int LABEL_W = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [LABEL_W-1:0] out_label;
    logic [10:0]        out_area;
    logic [4:0]         out_xmin;
    logic [4:0]         out_xmax;
    logic [4:0]         out_ymin;
    logic [4:0]         out_ymax;

    modport master (
        output out_valid,
        output out_label,
        output out_area,
        output out_xmin,
        output out_xmax,
        output out_ymin,
        output out_ymax,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_label,
        input  out_area,
        input  out_xmin,
        input  out_xmax,
        input  out_ymin,
        input  out_ymax,
        output out_ready
    );
endinterface

// File: rtl/cc_stats.sv
// cc_stats: per-label area/bbox statistics over a 32x32 label SRAM.
// Optional CC_STATS_OVF_EN: count out-of-range label pixels on ovf_cnt.
module cc_stats #(
    parameter int MAX_LABELS = 16,
    parameter int LABEL_BASE = 3,
    parameter int LABEL_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [9:0]         lbl_a,
    input  logic [LABEL_W-1:0] lbl_q,
    cc_stats_if.master         rec,
    output logic               busy,
    output logic               done,
    output logic [10:0]        ovf_cnt
);

    localparam int IW = (MAX_LABELS > 1) ? $clog2(MAX_LABELS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state;
    logic [9:0]    cnt;
    logic [9:0]    addr_d;
    logic          proc_v;
    logic [IW-1:0] idx;

    logic [10:0] area [MAX_LABELS];
    logic [4:0]  xmin [MAX_LABELS];
    logic [4:0]  xmax [MAX_LABELS];
    logic [4:0]  ymin [MAX_LABELS];
    logic [4:0]  ymax [MAX_LABELS];

    logic          accept;
    logic          hit;
    logic [IW-1:0] hidx;
    logic          cur_empty;
    logic          emit_adv;
    logic          last;
    logic [4:0]    px;
    logic [4:0]    py;

    assign accept    = start && (state == S_IDLE || state == S_DONE);
    assign cur_empty = (area[idx] == 11'd0);
    assign emit_adv  = (state == S_EMIT) && (cur_empty || rec.out_ready);
    assign last      = (idx == IW'(MAX_LABELS - 1));
    assign px        = addr_d[9:5];
    assign py        = addr_d[4:0];

    // Classify the pixel returned for addr_d into a table index
    always_comb begin
        hit  = 1'b0;
        hidx = '0;
        if (proc_v &&
            32'(lbl_q) >= 32'(LABEL_BASE) &&
            32'(lbl_q) <  32'(LABEL_BASE + MAX_LABELS)) begin
            hit  = 1'b1;
            hidx = IW'(32'(lbl_q) - 32'(LABEL_BASE));
        end
    end

    // Control FSM, scan counter and read-data alignment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_d <= '0;
            proc_v <= 1'b0;
            idx    <= '0;
        end else begin
            proc_v <= (state == S_SCAN);
            addr_d <= cnt;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state <= S_SCAN;
                        cnt   <= '0;
                        idx   <= '0;
                    end
                end
                S_SCAN: begin
                    if (cnt == 10'd1023) begin
                        state <= S_FLUSH;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_FLUSH: begin
                    state <= S_EMIT;
                    idx   <= '0;
                end
                S_EMIT: begin
                    if (emit_adv) begin
                        if (last) begin
                            state <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Label table: single-cycle read-modify-write per pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LABELS; i++) begin
                area[i] <= '0;
                xmin[i] <= 5'd31;
                xmax[i] <= 5'd0;
                ymin[i] <= 5'd31;
                ymax[i] <= 5'd0;
            end
        end else if (accept) begin
            for (int i = 0; i < MAX_LABELS; i++) begin
                area[i] <= '0;
                xmin[i] <= 5'd31;
                xmax[i] <= 5'd0;
                ymin[i] <= 5'd31;
                ymax[i] <= 5'd0;
            end
        end else if (hit) begin
            area[hidx] <= area[hidx] + 11'd1;
            if (px < xmin[hidx]) xmin[hidx] <= px;
            if (px > xmax[hidx]) xmax[hidx] <= px;
            if (py < ymin[hidx]) ymin[hidx] <= py;
            if (py > ymax[hidx]) ymax[hidx] <= py;
        end
    end

`ifdef CC_STATS_OVF_EN
    logic        oor;
    logic [10:0] ovf_r;

    assign oor = proc_v &&
                 32'(lbl_q) >= 32'(LABEL_BASE + MAX_LABELS);

    // Out-of-range pixel counter, held until the next accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= '0;
        end else if (accept) begin
            ovf_r <= '0;
        end else if (oor && ovf_r < 11'd1024) begin
            ovf_r <= ovf_r + 11'd1;
        end
    end

    assign ovf_cnt = ovf_r;
`else
    assign ovf_cnt = '0;
`endif

    assign lbl_a = cnt;
    assign busy  = (state == S_SCAN) ||
                   (state == S_FLUSH) ||
                   (state == S_EMIT);
    assign done  = (state == S_DONE);

    assign rec.out_valid = (state == S_EMIT) && !cur_empty;
    assign rec.out_label = rec.out_valid ?
        LABEL_W'(32'(idx) + 32'(LABEL_BASE)) : '0;
    assign rec.out_area  = rec.out_valid ? area[idx] : '0;
    assign rec.out_xmin  = rec.out_valid ? xmin[idx] : '0;
    assign rec.out_xmax  = rec.out_valid ? xmax[idx] : '0;
    assign rec.out_ymin  = rec.out_valid ? ymin[idx] : '0;
    assign rec.out_ymax  = rec.out_valid ? ymax[idx] : '0;

endmodule
